// File: rtl/riscv_pkg.sv
// Shared constants for the fetch/decode boundary: NOP encoding, register-field
// positions and the default datapath width.
package riscv_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int          RS1_LSB      = 15;
    localparam int          RS2_LSB      = 20;
    localparam int          REG_ADDR_W   = 5;

    // Saturating increment for the 32-bit event counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register holding {pc, instr, valid}.
// A flush loads a bubble and wins over a stalled (disabled) load.
module ifid_pipe_reg #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q,    pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = pc_i;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage_ifid_reg.sv
// Fetch stage: PC register with branch redirect and stall, feeding the IF/ID register.
// Optional perf counters are built only when IFID_PERF_CNT_EN is defined.
module if_stage_ifid_reg
    import riscv_pkg::*;
#(
    parameter int               XLEN      = riscv_pkg::XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCWrite,
    input  logic                  Write_IFID,
    input  logic                  branch_taken_EX,
    input  logic [XLEN-1:0]       branch_target_EX,
    output logic [XLEN-1:0]       imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic [XLEN-1:0]       pc_IFID,
    output logic [XLEN-1:0]       pc_plus4_IFID,
    output logic [31:0]           instr_IFID,
    output logic                  valid_IFID,
    output logic [REG_ADDR_W-1:0] rs1_IFID,
    output logic [REG_ADDR_W-1:0] rs2_IFID,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            unused_tgt_lsbs;

    // Targets are forced word-aligned; the low bits are deliberately dropped.
    assign unused_tgt_lsbs = ^branch_target_EX[1:0];

    always_comb begin
        pc_d = pc_q;
        if (branch_taken_EX)
            pc_d = {branch_target_EX[XLEN-1:2], 2'b00};
        else if (PCWrite)
            pc_d = pc_q + XLEN'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign imem_addr = pc_q;

    ifid_pipe_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (branch_taken_EX),
        .load_i  (Write_IFID),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .pc_o    (pc_IFID),
        .instr_o (instr_IFID),
        .valid_o (valid_IFID)
    );

    assign pc_plus4_IFID = pc_IFID + XLEN'(4);

    // Bubbles report x0 so the hazard unit never matches a stale source field.
    assign rs1_IFID = valid_IFID ? instr_IFID[RS1_LSB +: REG_ADDR_W] : '0;
    assign rs2_IFID = valid_IFID ? instr_IFID[RS2_LSB +: REG_ADDR_W] : '0;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!Write_IFID && !branch_taken_EX)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (branch_taken_EX)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage_ifid_reg.sv
// Scoreboard bench for if_stage_ifid_reg: directed vectors push expected state,
// a negedge monitor pops and compares.
module tb_if_stage_ifid_reg;

    typedef struct {
        bit          pcw;
        bit          wif;
        bit          br;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
        logic [31:0] e_stall;
        logic [31:0] e_flush;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        PCWrite;
    logic        Write_IFID;
    logic        branch_taken_EX;
    logic [31:0] branch_target_EX;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_IFID;
    logic [31:0] pc_plus4_IFID;
    logic [31:0] instr_IFID;
    logic        valid_IFID;
    logic [4:0]  rs1_IFID;
    logic [4:0]  rs2_IFID;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];
    vec_t vecs[14];

    if_stage_ifid_reg dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PCWrite          (PCWrite),
        .Write_IFID       (Write_IFID),
        .branch_taken_EX  (branch_taken_EX),
        .branch_target_EX (branch_target_EX),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .pc_IFID          (pc_IFID),
        .pc_plus4_IFID    (pc_plus4_IFID),
        .instr_IFID       (instr_IFID),
        .valid_IFID       (valid_IFID),
        .rs1_IFID         (rs1_IFID),
        .rs2_IFID         (rs2_IFID),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef IFID_PERF_CNT_EN
        return v;
`else
        return (v == v) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"},  imem_addr,  32'h0);
        chk({tag, "_pc"},    pc_IFID,    32'h0);
        chk({tag, "_instr"}, instr_IFID, 32'h0000_0013);
        chk({tag, "_valid"}, {31'd0, valid_IFID}, 32'd0);
        chk({tag, "_rs1"},   {27'd0, rs1_IFID},   32'd0);
        chk({tag, "_rs2"},   {27'd0, rs2_IFID},   32'd0);
        chk({tag, "_stall"}, stall_cnt,  32'd0);
        chk({tag, "_flush"}, flush_cnt,  32'd0);
    endtask

    // Monitor: the DUT presents its registered state every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_addr",  imem_addr,  e.addr);
            chk("pc_IFID",    pc_IFID,    e.pc);
            chk("pc_plus4",   pc_plus4_IFID, e.pc + 32'd4);
            chk("instr_IFID", instr_IFID, e.instr);
            chk("valid_IFID", {31'd0, valid_IFID}, {31'd0, e.valid});
            chk("rs1_IFID",   {27'd0, rs1_IFID},   {27'd0, e.rs1});
            chk("rs2_IFID",   {27'd0, rs2_IFID},   {27'd0, e.rs2});
            chk("stall_cnt",  stall_cnt,  cnt_exp(e.stall));
            chk("flush_cnt",  flush_cnt,  cnt_exp(e.flush));
        end
    end

    task automatic drive_and_push(input vec_t v);
        exp_t e;
        PCWrite          = v.pcw;
        Write_IFID       = v.wif;
        branch_taken_EX  = v.br;
        branch_target_EX = v.tgt;
        imem_rdata       = v.rdata;
        @(posedge clk);
        #1;
        e.addr  = v.e_addr;
        e.pc    = v.e_pc;
        e.instr = v.e_instr;
        e.valid = v.e_valid;
        e.rs1   = v.e_rs1;
        e.rs2   = v.e_rs2;
        e.stall = v.e_stall;
        e.flush = v.e_flush;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_drain: %0d entries left, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // pcw wif br  tgt           rdata         addr          pc_IFID       instr         v  rs1 rs2 stall flush
        vecs[0]  = '{1, 1, 0, 32'h0, 32'h0010_0093, 32'h0000_0004, 32'h0000_0000, 32'h0010_0093, 1, 0,  1,  0, 0};
        vecs[1]  = '{1, 1, 0, 32'h0, 32'h0030_8133, 32'h0000_0008, 32'h0000_0004, 32'h0030_8133, 1, 1,  3,  0, 0};
        vecs[2]  = '{1, 1, 0, 32'h0, 32'h0030_8133, 32'h0000_000C, 32'h0000_0008, 32'h0030_8133, 1, 1,  3,  0, 0};
        vecs[3]  = '{1, 1, 0, 32'h0, 32'h4052_0233, 32'h0000_0010, 32'h0000_000C, 32'h4052_0233, 1, 4,  5,  0, 0};
        vecs[4]  = '{0, 0, 0, 32'h0, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000C, 32'h4052_0233, 1, 4,  5,  1, 0};
        vecs[5]  = '{0, 0, 0, 32'h0, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000C, 32'h4052_0233, 1, 4,  5,  2, 0};
        vecs[6]  = '{1, 1, 0, 32'h0, 32'h00A5_0533, 32'h0000_0014, 32'h0000_0010, 32'h00A5_0533, 1, 10, 10, 2, 0};
        vecs[7]  = '{0, 0, 1, 32'h103, 32'h1111_1111, 32'h0000_0100, 32'h0000_0014, 32'h0000_0013, 0, 0, 0,  2, 1};
        vecs[8]  = '{1, 1, 0, 32'h0, 32'h0020_8093, 32'h0000_0104, 32'h0000_0100, 32'h0020_8093, 1, 1,  2,  2, 1};
        vecs[9]  = '{1, 0, 0, 32'h0, 32'h0000_0000, 32'h0000_0108, 32'h0000_0100, 32'h0020_8093, 1, 1,  2,  3, 1};
        vecs[10] = '{1, 1, 1, 32'hFFFF_FFFE, 32'h2222_2222, 32'hFFFF_FFFC, 32'h0000_0108, 32'h0000_0013, 0, 0, 0, 3, 2};
        vecs[11] = '{1, 1, 0, 32'h0, 32'h00C5_8633, 32'h0000_0000, 32'hFFFF_FFFC, 32'h00C5_8633, 1, 11, 12, 3, 2};
        vecs[12] = '{1, 1, 0, 32'h0, 32'h0000_0013, 32'h0000_0004, 32'h0000_0000, 32'h0000_0013, 1, 0,  0,  3, 2};
        vecs[13] = '{1, 1, 0, 32'h0, 32'h0030_8133, 32'h0000_0008, 32'h0000_0004, 32'h0030_8133, 1, 1,  3,  3, 2};

        rst_n            = 1'b0;
        PCWrite          = 1'b0;
        Write_IFID       = 1'b0;
        branch_taken_EX  = 1'b0;
        branch_target_EX = 32'h0;
        imem_rdata       = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_addr", imem_addr, 32'h0);

        foreach (vecs[i]) drive_and_push(vecs[i]);
        PCWrite    = 1'b0;
        Write_IFID = 1'b1;
        drain("main");

        // Asynchronous reset mid-cycle, well away from any clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_midreset_addr", imem_addr, 32'h0);

        drive_and_push('{1, 1, 0, 32'h0, 32'h0030_8133, 32'h0000_0004, 32'h0000_0000,
                         32'h0030_8133, 1, 1, 3, 0, 0});
        drain("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, limit 20000");
        $fatal(1, "timeout");
    end

endmodule
